// File: rtl/pwm_sample_buffer.sv
// -----------------------------------------------------------------------------
// pwm_sample_buffer
//
// Purpose:
//   Takes 8-bit waveform samples from the CORDIC sample-select mux through a
//   valid/ready handshake and stores them in a small FIFO. It releases one
//   sample per PWM period as the new duty value, which drives a PWM DAC on the
//   PMOD audio pin. The output rate does not depend on how fast samples arrive.
//
// Parameters:
//   SAMPLE_W  - sample width; one PWM period is 2^SAMPLE_W ticks
//   DEPTH     - FIFO entries (power of two, >= 4)
//   PRESCALE  - clocks per PWM tick (>= 1)
//   SIGNED_IN - 1: s_data is two's complement and is converted to offset binary
//
// Ports:
//   clock          in   system clock
//   reset          in   asynchronous, active-high reset
//   s_valid        in   sample offered
//   s_data         in   sample value
//   s_ready        out  FIFO can accept; transfer on s_valid & s_ready
//   enable         in   run PWM; 0 = idle, output low
//   clear_underrun in   clears the sticky underrun flag
//   pwm            out  registered PWM output
//   period_strobe  out  one-cycle pulse when a new period (duty) starts
//   level          out  FIFO occupancy
//   underrun       out  sticky: period boundary reached with FIFO empty
// -----------------------------------------------------------------------------
module pwm_sample_buffer #(
  parameter int SAMPLE_W  = 8,
  parameter int DEPTH     = 8,
  parameter int PRESCALE  = 4,
  parameter int SIGNED_IN = 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     s_valid,
  input  logic [SAMPLE_W-1:0]      s_data,
  output logic                     s_ready,
  input  logic                     enable,
  input  logic                     clear_underrun,
  output logic                     pwm,
  output logic                     period_strobe,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     underrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [SAMPLE_W-1:0] CNT_MAX  = '1;
  localparam logic [SAMPLE_W-1:0] MSB_MASK = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [LW-1:0]       LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0]       LVL_HALF = LW'(DEPTH / 2);
  localparam logic [PW-1:0]       PRE_MAX  = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  // FIFO storage and pointers
  logic [SAMPLE_W-1:0] mem [DEPTH];
  logic [AW-1:0]       wr_ptr_q;
  logic [AW-1:0]       rd_ptr_q;
  logic [LW-1:0]       level_q;

  // PWM engine state
  state_t              state_q;
  logic [PW-1:0]       presc_q;
  logic [SAMPLE_W-1:0] cnt_q;
  logic [SAMPLE_W-1:0] duty_q;
  logic                pwm_q;
  logic                strobe_q;
  logic                underrun_q;

  logic [SAMPLE_W-1:0] wr_data;
  logic                push;
  logic                pop;
  logic                tick;
  logic                boundary;
  logic                level_nz;
  logic                underrun_set;

  // Two's complement to offset binary is simply an MSB flip.
  assign wr_data = (SIGNED_IN != 0) ? (s_data ^ MSB_MASK) : s_data;

  // Ready comes from the registered level only, so a pop at full frees the
  // slot one cycle later. Held low for as long as reset is asserted.
  assign s_ready  = (level_q != LVL_FULL) & ~reset;
  assign push     = s_valid & s_ready;

  assign level_nz = (level_q != '0);
  assign tick     = (presc_q == PRE_MAX);
  assign boundary = (state_q == ST_RUN) & tick & (cnt_q == CNT_MAX);

  // Pops only read stored entries, never the word being written this
  // cycle, so a boundary with an empty FIFO stays an underrun even if a
  // push lands at the same time.
  assign pop = enable & (((state_q == ST_PRIME) & (level_q >= LVL_HALF)) |
                         (boundary & level_nz));
  assign underrun_set = enable & boundary & ~level_nz;

  // Storage array has no reset so it can map onto distributed/block RAM.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // PWM sequencer: IDLE -> PRIME (wait for half-full) -> RUN.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      cnt_q      <= '0;
      duty_q     <= '0;
      pwm_q      <= 1'b0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      // Gating with enable makes the output drop in the same cycle the
      // sequencer falls back to IDLE, not one cycle after.
      pwm_q <= (state_q == ST_RUN) & enable & (cnt_q < duty_q);
      // A new underrun beats a simultaneous clear so no event is lost.
      underrun_q <= underrun_set | (underrun_q & ~clear_underrun);

      case (state_q)
        ST_IDLE: begin
          presc_q <= '0;
          cnt_q   <= '0;
          if (enable) begin
            state_q <= ST_PRIME;
          end
        end

        ST_PRIME: begin
          presc_q <= '0;
          cnt_q   <= '0;
          if (!enable) begin
            state_q <= ST_IDLE;
          end else if (level_q >= LVL_HALF) begin
            state_q  <= ST_RUN;
            strobe_q <= 1'b1;
            duty_q   <= mem[rd_ptr_q];
          end
        end

        ST_RUN: begin
          if (!enable) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            cnt_q   <= '0;
          end else begin
            if (tick) begin
              presc_q <= '0;
              cnt_q   <= cnt_q + 1'b1;
            end else begin
              presc_q <= presc_q + 1'b1;
            end
            // On an empty boundary the previous duty is repeated.
            if (boundary) begin
              strobe_q <= 1'b1;
              if (level_nz) begin
                duty_q <= mem[rd_ptr_q];
              end
            end
          end
        end

        default: begin
          state_q <= ST_IDLE;
          presc_q <= '0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign pwm           = pwm_q;
  assign period_strobe = strobe_q;
  assign level         = level_q;
  assign underrun      = underrun_q;

endmodule
